gravador_sequencia: RTL

- Writer side of the sequence memory that the game datapath reads back and compares against `chaves`.
- The user sets a 4-bit digit on `chaves` and presses `gravar`. The block stores the digit at the next address of an internal RAM, until `N_JOGADAS` digits are stored.
- An independent synchronous read port lets the playing circuit fetch the recorded sequence.
- Contains its own control FSM, address counter, data register, button synchronizer/edge detector and 7-segment debug outputs.

---
 rtl/gravador_sequencia_if.sv | 26 ++
 rtl/gravador_sequencia.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gravador_sequencia_if.sv
// Port bundle for the sequence writer: user controls, read port and debug.
interface gravador_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic              gravar;
    logic [DATA_W-1:0] chaves;
    logic [ADDR_W-1:0] endereco_leitura;
    logic [DATA_W-1:0] dado_leitura;
    logic              ocupado;
    logic              pronto;
    logic              db_gravar;
    logic [6:0]        db_endereco;
    logic [6:0]        db_estado;

    // master drives the user-side inputs; slave is the writer block
    modport master (
        output iniciar, gravar, chaves, endereco_leitura,
        input  dado_leitura, ocupado, pronto, db_gravar, db_endereco, db_estado
    );
    modport slave (
        input  iniciar, gravar, chaves, endereco_leitura,
        output dado_leitura, ocupado, pronto, db_gravar, db_endereco, db_estado
    );
endinterface

// File: rtl/gravador_sequencia.sv
// Sequence writer: records digits from `chaves` into a RAM, one per button
// press, and exposes an independent synchronous read port for the game.

// Hex digit to 7-segment, active-high, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] sseg
);
    // pure lookup table
    always_comb begin
        sseg = 7'h00;
        case (hexa)
            4'h0: sseg = 7'h3F;
            4'h1: sseg = 7'h06;
            4'h2: sseg = 7'h5B;
            4'h3: sseg = 7'h4F;
            4'h4: sseg = 7'h66;
            4'h5: sseg = 7'h6D;
            4'h6: sseg = 7'h7D;
            4'h7: sseg = 7'h07;
            4'h8: sseg = 7'h7F;
            4'h9: sseg = 7'h6F;
            4'hA: sseg = 7'h77;
            4'hB: sseg = 7'h7C;
            4'hC: sseg = 7'h39;
            4'hD: sseg = 7'h5E;
            4'hE: sseg = 7'h79;
            4'hF: sseg = 7'h71;
            default: sseg = 7'h00;
        endcase
    end
endmodule

module gravador_sequencia #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int N_JOGADAS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    gravador_sequencia_if.slave  bus
);
    localparam int                PROF   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_JOGADAS - 1);

    // State codes double as the debug display value
    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h3,
        GRAVA      = 4'h4,
        PROXIMO    = 4'h5,
        FINAL      = 4'hF
    } estado_t;

    estado_t           estado, prox;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] dado_reg;
    logic [DATA_W-1:0] mem [PROF];
    logic              s1, s2, s3, gp;
    logic              zera, carrega, escreve, conta;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.gravar;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One pulse per press no matter how long the button is held
    assign gp            = s2 & ~s3;
    assign bus.db_gravar = s2;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox;
    end

    // Next state and datapath controls; terminal compare precedes increment
    always_comb begin
        prox        = estado;
        zera        = 1'b0;
        carrega     = 1'b0;
        escreve     = 1'b0;
        conta       = 1'b0;
        bus.ocupado = 1'b0;
        bus.pronto  = 1'b0;
        case (estado)
            INICIAL:    if (bus.iniciar) prox = PREPARACAO;
            PREPARACAO: begin
                zera        = 1'b1;
                bus.ocupado = 1'b1;
                prox        = ESPERA;
            end
            ESPERA: begin
                bus.ocupado = 1'b1;
                if (gp) prox = REGISTRA;
            end
            REGISTRA: begin
                carrega     = 1'b1;
                bus.ocupado = 1'b1;
                prox        = GRAVA;
            end
            GRAVA: begin
                escreve     = 1'b1;
                bus.ocupado = 1'b1;
                prox        = (cnt == ULTIMO) ? FINAL : PROXIMO;
            end
            PROXIMO: begin
                conta       = 1'b1;
                bus.ocupado = 1'b1;
                prox        = ESPERA;
            end
            FINAL: begin
                bus.pronto = 1'b1;
                if (bus.iniciar) prox = PREPARACAO;
            end
            default: prox = INICIAL;
        endcase
    end

    // Write address counter and captured digit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            dado_reg <= '0;
        end else begin
            if (zera)       cnt <= '0;
            else if (conta) cnt <= cnt + 1'b1;
            if (zera)         dado_reg <= '0;
            else if (carrega) dado_reg <= bus.chaves;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (escreve) mem[cnt] <= dado_reg;
    end

    // Registered read port; same-address write shows old data this cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) bus.dado_leitura <= '0;
        else        bus.dado_leitura <= mem[bus.endereco_leitura];
    end

    logic [3:0] cnt_nib;
    assign cnt_nib = 4'(cnt);

    hexa7seg u_hex_end (.hexa(cnt_nib),        .sseg(bus.db_endereco));
    hexa7seg u_hex_est (.hexa(4'(estado)),     .sseg(bus.db_estado));
endmodule
